dual_port_ram_sync_param: RTL and testbench
===========================================

Name: dual_port_ram_sync_param

Overview:
- Parametrised true dual-port RAM on a single clock: two independent read/write ports, per-byte write enables and synchronous registered reads.
- Adds a selectable read-during-write mode, an optional extra output register, per-port read-valid flags, write-collision detection and a power-up clear sequencer.
- Serves as the general on-chip buffer for datapath blocks that need two concurrent accessors.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of BYTE_W
BYTE_W, 8, byte-lane width for write enables
ADDR_W, 6, address width
DEPTH, 64, number of words; DEPTH <= 2**ADDR_W
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data)
OUT_REG, 0, 1 = add a second output register stage
INIT_CLEAR, 1, 1 = zero all words after reset

Ports:
CLK  input  1  clock; all logic on rising edge
RST_N  input  1  asynchronous, active-low reset
a_en  input  1  port A access enable
a_we  input  1  port A write (qualified by a_en)
a_be  input  DATA_W/BYTE_W  port A byte-lane write enables
a_addr  input  ADDR_W  port A address
a_di  input  DATA_W  port A write data
a_do  output  DATA_W  port A read data
a_vld  output  1  a_do updated this cycle
b_en, b_we, b_be, b_addr, b_di, b_do, b_vld  same as port A, for port B
init_busy  output  1  clear sequence in progress; ports ignored
collision  output  1  one-cycle pulse: both ports wrote the same byte of the same word

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low (RST_N).
- Reset values: a_do = b_do = 0, a_vld = b_vld = 0, collision = 0, init_busy = INIT_CLEAR, clear counter = 0. RST_N does not touch memory contents directly.
- FSM states: INIT, READY.
  - Reset enters INIT if INIT_CLEAR = 1, otherwise READY.
  - In INIT, word[cnt] is written to 0 and cnt increments by 1 every cycle.
  - When cnt == DEPTH-1, the FSM moves to READY on the next edge and init_busy falls. INIT therefore lasts exactly DEPTH cycles.
  - Reset asserted during INIT restarts the clear from address 0.
- While in INIT: a_en and b_en are treated as 0, vld stays 0 and collision stays 0.
- Access: an access occurs when x_en = 1 in READY. Every access, write or read, produces a read.
- Read latency: L = 1 + OUT_REG cycles from the access edge.
  - x_vld pulses high in the cycle x_do presents that access's data.
  - x_do holds its last value when there is no new access.
- Writes: on x_en & x_we, byte lane i of word[addr] is written with x_di lane i only where x_be[i] = 1. x_we with x_be = 0 writes nothing but still reads.
- Same-port read-during-write:
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns the merged word (enabled lanes new, others old).
- Cross-port read-during-write: port X reading the address port Y writes in the same cycle always returns the pre-write word, regardless of RDW_MODE.
- Simultaneous writes to the same address:
  - Lanes enabled on only one port take that port's data.
  - Lanes enabled on both ports take port A's data.
  - collision is registered: it pulses 1 the cycle after any lane is enabled on both ports.
- Out-of-range address (addr >= DEPTH): the write is dropped and the read returns 0. vld still pulses.
- Back-to-back accesses every cycle are supported on both ports; the output register stages pipeline without stalls.
- Reset mid-operation: in-flight reads are discarded (vld = 0, do = 0). Memory is preserved when INIT_CLEAR = 0.

Decomposition:
- Package dp_ram_pkg:
  - constants RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1
  - FSM state typedef {INIT, READY}
  - function computing byte-lane count DATA_W/BYTE_W
- Sub-module dp_ram_port_pipe, instantiated once per port:
  - takes raw read word plus access strobe
  - implements the OUT_REG stage, data hold and vld pipeline with reset
- Memory array, write merge/arbitration and FSM stay in the top module.

Test Plan:
- Clear after reset (defaults): release RST_N, hold a_en = 1 -> init_busy high exactly 64 cycles, a_vld stays 0; then read addresses 0..63 -> all 0x0000.
- Byte-enable write: A writes 0xBEEF at addr 5 with be = 11, then writes 0x1234 with be = 01 -> a read of 5 returns 0xBE34 with a_vld one cycle after the read edge (OUT_REG = 0) or two cycles (OUT_REG = 1).
- Read-during-write: addr 9 holds 0x1111; A writes 0x2222 to 9 -> a_do = 0x1111 (RDW_MODE = 0) or 0x2222 (RDW_MODE = 1); B reading 9 in the same cycle gets 0x1111 in both modes.
- Collision: A writes 0xAAAA be = 11 and B writes 0x5555 be = 10 to addr 3 in the same cycle -> word[3] = 0xAAAA, collision pulses the next cycle. Repeat with A be = 01, B be = 10 -> word[3] = 0x55AA, no collision.
- Out-of-range (DEPTH = 48): write 0xFFFF to addr 50 -> a read of 50 returns 0, vld pulses, and word[50 mod 48 = 2] is unchanged.
- Reset mid-stream: continuous reads on both ports with OUT_REG = 1; pulse RST_N low mid-pipeline -> do = 0 and vld = 0 immediately (asynchronous). With INIT_CLEAR = 0, prior data is readable after release.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared constants and types for the dual-port synchronous RAM.
package dp_ram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   typedef enum logic {INIT, READY} state_t;

   function automatic int lane_count(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

endpackage

// File: rtl/dp_ram_port_pipe.sv
// Per-port read pipeline: access register, optional second stage, data hold and valid.
module dp_ram_port_pipe #(
   parameter int DATA_W  = 16,
   parameter int OUT_REG = 0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              acc,
   input  logic [DATA_W-1:0] raw,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_vld
);

   logic [DATA_W-1:0] s1_data_reg;
   logic              s1_vld_reg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_data_reg <= '0;
         s1_vld_reg  <= 1'b0;
      end else begin
         s1_vld_reg <= acc;
         if (acc) s1_data_reg <= raw;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] s2_data_reg;
         logic              s2_vld_reg;

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               s2_data_reg <= '0;
               s2_vld_reg  <= 1'b0;
            end else begin
               s2_vld_reg <= s1_vld_reg;
               if (s1_vld_reg) s2_data_reg <= s1_data_reg;
            end
         end

         assign rd_data = s2_data_reg;
         assign rd_vld  = s2_vld_reg;
      end else begin : g_no_out_reg
         assign rd_data = s1_data_reg;
         assign rd_vld  = s1_vld_reg;
      end
   endgenerate

endmodule

// File: rtl/dual_port_ram_sync_param.sv
// Single-clock true dual-port RAM with byte lanes, selectable read-during-write,
// optional output register, collision flag and power-up clear.
module dual_port_ram_sync_param
   import dp_ram_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int BYTE_W     = 8,
   parameter int ADDR_W     = 6,
   parameter int DEPTH      = 64,
   parameter int RDW_MODE   = 0,
   parameter int OUT_REG    = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       a_en,
   input  logic                       a_we,
   input  logic [DATA_W/BYTE_W-1:0]   a_be,
   input  logic [ADDR_W-1:0]          a_addr,
   input  logic [DATA_W-1:0]          a_di,
   output logic [DATA_W-1:0]          a_do,
   output logic                       a_vld,
   input  logic                       b_en,
   input  logic                       b_we,
   input  logic [DATA_W/BYTE_W-1:0]   b_be,
   input  logic [ADDR_W-1:0]          b_addr,
   input  logic [DATA_W-1:0]          b_di,
   output logic [DATA_W-1:0]          b_do,
   output logic                       b_vld,
   output logic                       init_busy,
   output logic                       collision
);

   localparam int LANES = lane_count(DATA_W, BYTE_W);
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t              state_reg;
   logic [ADDR_W-1:0]   cnt_reg;
   logic                init_busy_reg;
   logic                collision_reg;

   logic                ready;
   logic                a_acc, b_acc;
   logic                a_ok, b_ok;
   logic [LANES-1:0]    a_lane_we, b_lane_we;
   logic [DATA_W-1:0]   a_old, b_old;
   logic [DATA_W-1:0]   a_merge, b_merge;
   logic [DATA_W-1:0]   a_raw, b_raw;
   logic                collision_next;

   assign ready = (state_reg == READY);
   assign a_acc = ready & a_en;
   assign b_acc = ready & b_en;
   assign a_ok  = int'(a_addr) < DEPTH;
   assign b_ok  = int'(b_addr) < DEPTH;

   // Out-of-range addresses neither write nor read memory.
   assign a_lane_we = (a_acc & a_we & a_ok) ? a_be : '0;
   assign b_lane_we = (b_acc & b_we & b_ok) ? b_be : '0;

   assign a_old = a_ok ? mem[a_addr] : '0;
   assign b_old = b_ok ? mem[b_addr] : '0;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign a_merge[gi*BYTE_W +: BYTE_W] = a_lane_we[gi] ? a_di[gi*BYTE_W +: BYTE_W]
                                                            : a_old[gi*BYTE_W +: BYTE_W];
         assign b_merge[gi*BYTE_W +: BYTE_W] = b_lane_we[gi] ? b_di[gi*BYTE_W +: BYTE_W]
                                                            : b_old[gi*BYTE_W +: BYTE_W];
      end
   endgenerate

   // Write-first only merges a port's own write; the other port always sees old data.
   assign a_raw = (RDW_MODE == RDW_WRITE_FIRST) ? a_merge : a_old;
   assign b_raw = (RDW_MODE == RDW_WRITE_FIRST) ? b_merge : b_old;

   assign collision_next = (a_addr == b_addr) && ((a_lane_we & b_lane_we) != '0);

   // Port B lanes are applied first so port A wins on lanes both ports enable.
   always_ff @(posedge CLK) begin
      if (state_reg == INIT) begin
         mem[cnt_reg] <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (b_lane_we[i]) mem[b_addr][i*BYTE_W +: BYTE_W] <= b_di[i*BYTE_W +: BYTE_W];
         end
         for (int i = 0; i < LANES; i++) begin
            if (a_lane_we[i]) mem[a_addr][i*BYTE_W +: BYTE_W] <= a_di[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg     <= (INIT_CLEAR != 0) ? INIT : READY;
         init_busy_reg <= (INIT_CLEAR != 0);
         cnt_reg       <= '0;
         collision_reg <= 1'b0;
      end else begin
         collision_reg <= collision_next;
         case (state_reg)
            INIT: begin
               if (cnt_reg == CNT_LAST) begin
                  state_reg     <= READY;
                  init_busy_reg <= 1'b0;
                  cnt_reg       <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            READY:   ;
            default: state_reg <= READY;
         endcase
      end
   end

   assign init_busy = init_busy_reg;
   assign collision = collision_reg;

   dp_ram_port_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_a (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .acc     (a_acc),
      .raw     (a_raw),
      .rd_data (a_do),
      .rd_vld  (a_vld)
   );

   dp_ram_port_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_b (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .acc     (b_acc),
      .raw     (b_raw),
      .rd_data (b_do),
      .rd_vld  (b_vld)
   );

endmodule

// File: tb/tb_dual_port_ram_sync_param.sv
// Bench for two RAM configurations: defaults, and DEPTH=48/OUT_REG=1/write-first/no clear.
module tb_dual_port_ram_sync_param;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst_n [2];
   logic        en    [2][2];
   logic        we    [2][2];
   logic [1:0]  be    [2][2];
   logic [5:0]  addr  [2][2];
   logic [15:0] di    [2][2];
   logic [15:0] dout  [2][2];
   logic        vld   [2][2];
   logic        coll  [2];
   logic        busy  [2];

   dual_port_ram_sync_param u_dut0 (
      .CLK(CLK), .RST_N(rst_n[0]),
      .a_en(en[0][0]), .a_we(we[0][0]), .a_be(be[0][0]), .a_addr(addr[0][0]), .a_di(di[0][0]),
      .a_do(dout[0][0]), .a_vld(vld[0][0]),
      .b_en(en[0][1]), .b_we(we[0][1]), .b_be(be[0][1]), .b_addr(addr[0][1]), .b_di(di[0][1]),
      .b_do(dout[0][1]), .b_vld(vld[0][1]),
      .init_busy(busy[0]), .collision(coll[0])
   );

   dual_port_ram_sync_param #(.DEPTH(48), .OUT_REG(1), .RDW_MODE(1), .INIT_CLEAR(0)) u_dut1 (
      .CLK(CLK), .RST_N(rst_n[1]),
      .a_en(en[1][0]), .a_we(we[1][0]), .a_be(be[1][0]), .a_addr(addr[1][0]), .a_di(di[1][0]),
      .a_do(dout[1][0]), .a_vld(vld[1][0]),
      .b_en(en[1][1]), .b_we(we[1][1]), .b_be(be[1][1]), .b_addr(addr[1][1]), .b_di(di[1][1]),
      .b_do(dout[1][1]), .b_vld(vld[1][1]),
      .init_busy(busy[1]), .collision(coll[1])
   );

   // Reference model state
   logic [15:0] mm [2][64];
   int          busy_left [2];
   int          ecnt [2];
   logic        sv [2][2][4];
   logic [15:0] sd [2][2][4];
   logic [15:0] exp_do [2][2];
   logic        exp_vld [2][2];
   logic        exp_coll [2];
   int          total = 0;
   int          bad = 0;

   function automatic int dep(input int d);  return (d == 0) ? 64 : 48; endfunction
   function automatic int lat(input int d);  return (d == 0) ? 1 : 2;   endfunction
   function automatic int rdw(input int d);  return d;                  endfunction
   function automatic int iclr(input int d); return (d == 0) ? 1 : 0;   endfunction

   task automatic model_reset(input int d);
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 4; k++) sv[d][p][k] = 1'b0;
         exp_do[d][p]  = 16'h0;
         exp_vld[d][p] = 1'b0;
      end
      exp_coll[d]  = 1'b0;
      busy_left[d] = (iclr(d) != 0) ? dep(d) : 0;
      if (iclr(d) != 0) for (int a = 0; a < 64; a++) mm[d][a] = 16'h0;
   endtask

   task automatic set_port(input int d, input int p, input logic e, input logic w,
                           input logic [1:0] b, input int a, input logic [15:0] v);
      en[d][p] = e; we[d][p] = w; be[d][p] = b; addr[d][p] = 6'(a); di[d][p] = v;
   endtask

   task automatic idle();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            en[d][p] = 1'b0; we[d][p] = 1'b0; be[d][p] = 2'b00;
         end
   endtask

   // Applies the spec rules for the coming edge to the model, then clocks.
   task automatic step();
      logic        busy_now, inr;
      logic        acc [2];
      logic        wr  [2];
      logic [15:0] rd  [2];
      logic        cn  [2];
      for (int d = 0; d < 2; d++) begin
         busy_now = busy_left[d] > 0;
         for (int p = 0; p < 2; p++) begin
            acc[p] = !busy_now && en[d][p];
            inr    = int'(addr[d][p]) < dep(d);
            wr[p]  = acc[p] && we[d][p] && inr;
            rd[p]  = inr ? mm[d][addr[d][p]] : 16'h0;
            if (rdw(d) == 1 && wr[p])
               for (int i = 0; i < 2; i++)
                  if (be[d][p][i]) rd[p][i*8 +: 8] = di[d][p][i*8 +: 8];
         end
         cn[d] = wr[0] && wr[1] && (addr[d][0] == addr[d][1]) && ((be[d][0] & be[d][1]) != 2'b00);
         for (int p = 1; p >= 0; p--)
            if (wr[p])
               for (int i = 0; i < 2; i++)
                  if (be[d][p][i]) mm[d][addr[d][p]][i*8 +: 8] = di[d][p][i*8 +: 8];
         for (int p = 0; p < 2; p++)
            if (acc[p]) begin
               sv[d][p][(ecnt[d] + lat(d)) % 4] = 1'b1;
               sd[d][p][(ecnt[d] + lat(d)) % 4] = rd[p];
            end
         if (busy_now) busy_left[d]--;
         if (en[d][0] || en[d][1])
            $display("txn t=%0t d%0d A:en%b we%b be%b a%0d di=%h B:en%b we%b be%b a%0d di=%h",
                     $time, d, en[d][0], we[d][0], be[d][0], addr[d][0], di[d][0],
                     en[d][1], we[d][1], be[d][1], addr[d][1], di[d][1]);
      end
      @(posedge CLK);
      #1;
      for (int d = 0; d < 2; d++) begin
         ecnt[d]++;
         for (int p = 0; p < 2; p++) begin
            exp_vld[d][p] = sv[d][p][ecnt[d] % 4];
            if (sv[d][p][ecnt[d] % 4]) exp_do[d][p] = sd[d][p][ecnt[d] % 4];
            sv[d][p][ecnt[d] % 4] = 1'b0;
         end
         exp_coll[d] = cn[d];
      end
   endtask

   task automatic drain(input int d);
      idle();
      for (int k = 1; k < lat(d); k++) step();
   endtask

   task automatic test_reset();
      #1;
      rst_n[0] = 1'b0; rst_n[1] = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         for (int p = 0; p < 2; p++) begin
            total++;
            if (dout[d][p] !== 16'h0) begin bad++; $display("FAIL reset_do d%0d p%0d got=%h want=0000", d, p, dout[d][p]); end
            total++;
            if (vld[d][p] !== 1'b0) begin bad++; $display("FAIL reset_vld d%0d p%0d got=%b want=0", d, p, vld[d][p]); end
         end
         total++;
         if (coll[d] !== 1'b0) begin bad++; $display("FAIL reset_coll d%0d got=%b want=0", d, coll[d]); end
         total++;
         if (busy[d] !== (iclr(d) != 0)) begin bad++; $display("FAIL reset_busy d%0d got=%b want=%b", d, busy[d], iclr(d) != 0); end
      end
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
   endtask

   task automatic test_clear();
      int high_cnt;
      high_cnt = (busy[0] === 1'b1) ? 1 : 0;
      set_port(0, 0, 1'b1, 1'b1, 2'b11, 7, 16'hFFFF);
      for (int i = 0; i < 64; i++) begin
         step();
         if (busy[0] === 1'b1) high_cnt++;
         total++;
         if (busy[0] !== (i < 63)) begin bad++; $display("FAIL clear_busy cyc%0d got=%b want=%b", i, busy[0], i < 63); end
         total++;
         if (vld[0][0] !== 1'b0) begin bad++; $display("FAIL clear_vld cyc%0d got=%b want=0", i, vld[0][0]); end
      end
      total++;
      if (high_cnt != 64) begin bad++; $display("FAIL clear_len got=%0d want=64", high_cnt); end
      for (int a = 0; a < 64; a++) begin
         set_port(0, 0, 1'b1, 1'b0, 2'b00, a, 16'h0);
         step();
         total++;
         if (dout[0][0] !== 16'h0 || vld[0][0] !== 1'b1)
            begin bad++; $display("FAIL clear_read a%0d got=%h/%b want=0000/1", a, dout[0][0], vld[0][0]); end
      end
      idle();
      step();
   endtask

   task automatic test_fill();
      for (int a = 0; a < 48; a++) begin
         set_port(1, 0, 1'b1, 1'b1, 2'b11, a, 16'($urandom));
         step();
      end
      idle();
      step(); step();
   endtask

   task automatic test_byte_enable();
      for (int d = 0; d < 2; d++) begin
         set_port(d, 0, 1'b1, 1'b1, 2'b11, 5, 16'hBEEF); step();
         set_port(d, 0, 1'b1, 1'b1, 2'b01, 5, 16'h1234); step();
         set_port(d, 0, 1'b1, 1'b0, 2'b00, 5, 16'h0);    step();
         drain(d);
         total++;
         if (dout[d][0] !== 16'hBE34 || vld[d][0] !== 1'b1)
            begin bad++; $display("FAIL be_read d%0d got=%h/%b want=be34/1", d, dout[d][0], vld[d][0]); end
         idle(); step();
         total++;
         if (vld[d][0] !== 1'b0 || dout[d][0] !== 16'hBE34)
            begin bad++; $display("FAIL be_hold d%0d got=%h/%b want=be34/0", d, dout[d][0], vld[d][0]); end
      end
   endtask

   task automatic test_rdw();
      logic [15:0] want_a;
      for (int d = 0; d < 2; d++) begin
         set_port(d, 0, 1'b1, 1'b1, 2'b11, 9, 16'h1111); step();
         set_port(d, 0, 1'b1, 1'b1, 2'b11, 9, 16'h2222);
         set_port(d, 1, 1'b1, 1'b0, 2'b00, 9, 16'h0);
         step();
         drain(d);
         want_a = (rdw(d) == 1) ? 16'h2222 : 16'h1111;
         total++;
         if (dout[d][0] !== want_a || vld[d][0] !== 1'b1)
            begin bad++; $display("FAIL rdw_same d%0d got=%h/%b want=%h/1", d, dout[d][0], vld[d][0], want_a); end
         total++;
         if (dout[d][1] !== 16'h1111 || vld[d][1] !== 1'b1)
            begin bad++; $display("FAIL rdw_cross d%0d got=%h/%b want=1111/1", d, dout[d][1], vld[d][1]); end
         idle(); step();
      end
   endtask

   task automatic test_collision();
      for (int d = 0; d < 2; d++) begin
         set_port(d, 0, 1'b1, 1'b1, 2'b11, 3, 16'hAAAA);
         set_port(d, 1, 1'b1, 1'b1, 2'b10, 3, 16'h5555);
         step();
         total++;
         if (coll[d] !== 1'b1) begin bad++; $display("FAIL coll_pulse d%0d got=%b want=1", d, coll[d]); end
         set_port(d, 0, 1'b1, 1'b0, 2'b00, 3, 16'h0);
         set_port(d, 1, 1'b0, 1'b0, 2'b00, 3, 16'h0);
         step();
         total++;
         if (coll[d] !== 1'b0) begin bad++; $display("FAIL coll_fall d%0d got=%b want=0", d, coll[d]); end
         drain(d);
         total++;
         if (dout[d][0] !== 16'hAAAA) begin bad++; $display("FAIL coll_word d%0d got=%h want=aaaa", d, dout[d][0]); end
         set_port(d, 0, 1'b1, 1'b1, 2'b01, 3, 16'hAAAA);
         set_port(d, 1, 1'b1, 1'b1, 2'b10, 3, 16'h5555);
         step();
         total++;
         if (coll[d] !== 1'b0) begin bad++; $display("FAIL coll_none d%0d got=%b want=0", d, coll[d]); end
         set_port(d, 0, 1'b1, 1'b0, 2'b00, 3, 16'h0);
         set_port(d, 1, 1'b0, 1'b0, 2'b00, 3, 16'h0);
         step();
         drain(d);
         total++;
         if (dout[d][0] !== 16'h55AA) begin bad++; $display("FAIL coll_merge d%0d got=%h want=55aa", d, dout[d][0]); end
         idle(); step();
      end
   endtask

   task automatic test_out_of_range();
      logic [15:0] saved;
      saved = mm[1][2];
      set_port(1, 0, 1'b1, 1'b1, 2'b11, 50, 16'hFFFF); step();
      set_port(1, 0, 1'b1, 1'b0, 2'b00, 50, 16'h0);    step();
      drain(1);
      total++;
      if (dout[1][0] !== 16'h0 || vld[1][0] !== 1'b1)
         begin bad++; $display("FAIL oor_read got=%h/%b want=0000/1", dout[1][0], vld[1][0]); end
      set_port(1, 0, 1'b1, 1'b0, 2'b00, 2, 16'h0); step();
      drain(1);
      total++;
      if (dout[1][0] !== saved) begin bad++; $display("FAIL oor_alias got=%h want=%h", dout[1][0], saved); end
      idle(); step();
   endtask

   task automatic test_random();
      int a;
      for (int n = 0; n < 300; n++) begin
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
               a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 63);
               set_port(d, p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        2'($urandom_range(0, 3)), a, 16'($urandom));
            end
         step();
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               total++;
               if (vld[d][p] !== exp_vld[d][p])
                  begin bad++; $display("FAIL rnd_vld n%0d d%0d p%0d got=%b want=%b", n, d, p, vld[d][p], exp_vld[d][p]); end
               total++;
               if (dout[d][p] !== exp_do[d][p])
                  begin bad++; $display("FAIL rnd_do n%0d d%0d p%0d got=%h want=%h", n, d, p, dout[d][p], exp_do[d][p]); end
            end
            total++;
            if (coll[d] !== exp_coll[d])
               begin bad++; $display("FAIL rnd_coll n%0d d%0d got=%b want=%b", n, d, coll[d], exp_coll[d]); end
         end
      end
      idle(); step(); step();
   endtask

   task automatic test_reset_mid();
      logic [15:0] saved;
      saved = mm[1][7];
      for (int k = 0; k < 5; k++) begin
         set_port(1, 0, 1'b1, 1'b0, 2'b00, $urandom_range(0, 47), 16'h0);
         set_port(1, 1, 1'b1, 1'b0, 2'b00, $urandom_range(0, 47), 16'h0);
         step();
      end
      rst_n[1] = 1'b0;
      #2;
      model_reset(1);
      for (int p = 0; p < 2; p++) begin
         total++;
         if (dout[1][p] !== 16'h0 || vld[1][p] !== 1'b0)
            begin bad++; $display("FAIL mid_reset p%0d got=%h/%b want=0000/0", p, dout[1][p], vld[1][p]); end
      end
      rst_n[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         set_port(1, 0, 1'b1, 1'b0, 2'b00, $urandom_range(0, 47), 16'h0);
         set_port(1, 1, 1'b1, 1'b0, 2'b00, 7, 16'h0);
         step();
         for (int p = 0; p < 2; p++) begin
            total++;
            if (dout[1][p] !== exp_do[1][p] || vld[1][p] !== exp_vld[1][p])
               begin bad++; $display("FAIL mid_after k%0d p%0d got=%h/%b want=%h/%b", k, p, dout[1][p], vld[1][p], exp_do[1][p], exp_vld[1][p]); end
         end
      end
      total++;
      if (dout[1][1] !== saved || vld[1][1] !== 1'b1)
         begin bad++; $display("FAIL mid_keep got=%h/%b want=%h/1", dout[1][1], vld[1][1], saved); end
      idle(); step(); step();
   endtask

   initial begin
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      for (int d = 0; d < 2; d++) begin
         ecnt[d] = 0;
         for (int p = 0; p < 2; p++) set_port(d, p, 1'b0, 1'b0, 2'b00, 0, 16'h0);
      end
      test_reset();
      test_clear();
      test_fill();
      test_byte_enable();
      test_rdw();
      test_collision();
      test_out_of_range();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
